// File: rtl/decoder_pkg.sv
// Shared types and constants for the decoder_n_pipe family: decode mode,
// output buffer state encoding and the legal range of the index width.
package decoder_pkg;

  localparam int IN_W_MIN = 1;
  localparam int IN_W_MAX = 6;

  typedef enum logic {
    DEC_ONEHOT = 1'b0,
    DEC_THERM  = 1'b1
  } dec_mode_e;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_e;

endpackage

// File: rtl/dec_skid_buf.sv
// Output buffer with valid/ready handshake. DECODER_N_PIPE_SKID_EN selects a
// 2-entry skid buffer with a registered in_ready; otherwise a single stage.
module dec_skid_buf
  import decoder_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  buf_state_e   state_q, state_d;
  logic [W-1:0] head_q, head_d;
  logic         ready_q, ready_d;
  logic         accept_s;
  logic         drain_s;

  assign out_valid = (state_q != BUF_EMPTY);
  assign out_data  = head_q;
  assign drain_s   = (state_q != BUF_EMPTY) && out_ready;

`ifdef DECODER_N_PIPE_SKID_EN
  logic [W-1:0] skid_q, skid_d;

  // in_ready comes straight from a flop, so upstream never sees out_ready
  assign in_ready = ready_q;
  assign accept_s = in_valid && ready_q;

  // Next-state and storage steering for the two-entry buffer
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    case (state_q)
      BUF_EMPTY: begin
        if (accept_s) begin
          head_d  = in_data;
          state_d = BUF_ONE;
        end else begin
          state_d = BUF_EMPTY;
        end
      end
      BUF_ONE: begin
        if (accept_s && drain_s) begin
          head_d  = in_data;
          state_d = BUF_ONE;
        end else if (accept_s) begin
          skid_d  = in_data;
          state_d = BUF_TWO;
        end else if (drain_s) begin
          state_d = BUF_EMPTY;
        end else begin
          state_d = BUF_ONE;
        end
      end
      BUF_TWO: begin
        if (drain_s) begin
          head_d  = skid_q;
          state_d = BUF_ONE;
        end else begin
          state_d = BUF_TWO;
        end
      end
      default: begin
        state_d = BUF_EMPTY;
      end
    endcase
    ready_d = (state_d != BUF_TWO);
  end

  // Skid entry register
  always_ff @(posedge clk) begin
    if (rst) begin
      skid_q <= '0;
    end else begin
      skid_q <= skid_d;
    end
  end
`else
  // ready_q only gates the post-reset cycle; the rest is a combinational bypass
  assign in_ready = ready_q && (!out_valid || out_ready);
  assign accept_s = in_valid && in_ready;

  // Next-state for the single-stage buffer; BUF_TWO is never entered
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    case (state_q)
      BUF_EMPTY: begin
        if (accept_s) begin
          head_d  = in_data;
          state_d = BUF_ONE;
        end else begin
          state_d = BUF_EMPTY;
        end
      end
      BUF_ONE: begin
        if (accept_s) begin
          head_d  = in_data;
          state_d = BUF_ONE;
        end else if (drain_s) begin
          state_d = BUF_EMPTY;
        end else begin
          state_d = BUF_ONE;
        end
      end
      default: begin
        state_d = BUF_EMPTY;
      end
    endcase
    ready_d = 1'b1;
  end
`endif

  // State, head entry and ready registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BUF_EMPTY;
      head_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      ready_q <= ready_d;
    end
  end

endmodule

// File: rtl/decoder_n_pipe.sv
// Pipelined binary-to-one-hot/thermometer decoder with popcount output.
// Buffering scheme selected by macro DECODER_N_PIPE_SKID_EN (see dec_skid_buf).
module decoder_n_pipe
  import decoder_pkg::*;
#(
  parameter int IN_W = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_W-1:0]      in_idx,
  input  logic                 in_mode,
  input  logic                 in_en,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2**IN_W-1:0]   out_vec,
  output logic [IN_W:0]        out_cnt
);

  localparam int OUT_W = 2**IN_W;
  localparam int PW    = OUT_W + IN_W + 1;

  if ((IN_W < IN_W_MIN) || (IN_W > IN_W_MAX)) begin : g_bad_in_w
    $error("decoder_n_pipe: IN_W outside legal range");
  end

  logic [OUT_W-1:0] onehot_s;
  logic [OUT_W-1:0] therm_s;
  logic [OUT_W-1:0] vec_s;
  logic [IN_W:0]    cnt_s;
  logic [PW-1:0]    pay_in_s;
  logic [PW-1:0]    pay_out_s;

  assign onehot_s = {{(OUT_W-1){1'b0}}, 1'b1} << in_idx;
  // (onehot << 1) - 1 wraps to all-ones for the top index, which is exactly the full thermometer
  assign therm_s  = {onehot_s[OUT_W-2:0], 1'b0} - {{(OUT_W-1){1'b0}}, 1'b1};

  // Decode select and popcount
  always_comb begin
    vec_s = '0;
    cnt_s = '0;
    if (!in_en) begin
      vec_s = '0;
      cnt_s = '0;
    end else if (in_mode == DEC_THERM) begin
      vec_s = therm_s;
      cnt_s = {1'b0, in_idx} + {{IN_W{1'b0}}, 1'b1};
    end else begin
      vec_s = onehot_s;
      cnt_s = {{IN_W{1'b0}}, 1'b1};
    end
  end

  assign pay_in_s = {cnt_s, vec_s};

  dec_skid_buf #(
    .W (PW)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (pay_in_s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (pay_out_s)
  );

  assign out_vec = pay_out_s[OUT_W-1:0];
  assign out_cnt = pay_out_s[PW-1:OUT_W];

endmodule

// File: doc/decoder_n_pipe.md
DECODER_N_PIPE -- requirements
Module: decoder_n_pipe

Interface
REQ-001 SHALL have parameter IN_W, default 3: width of the binary index input (1..6 legal).
REQ-002 SHALL derive localparam OUT_W = 2**IN_W, which is not overridable.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: upstream request valid.
REQ-006 SHALL have port in_ready, output, 1 bit: block can accept a request this cycle.
REQ-007 SHALL have port in_idx, input, IN_W bits: binary index to decode.
REQ-008 SHALL have port in_mode, input, 1 bit: 0 = one-hot, 1 = thermometer.
REQ-009 SHALL have port in_en, input, 1 bit: 0 forces an all-zero decode.
REQ-010 SHALL have port out_valid, output, 1 bit: decoded word valid.
REQ-011 SHALL have port out_ready, input, 1 bit: downstream accepts.
REQ-012 SHALL have port out_vec, output, OUT_W bits: decoded word.
REQ-013 SHALL have port out_cnt, output, IN_W+1 bits: popcount of out_vec.

Function
REQ-014 SHALL treat a transfer as occurring on any cycle with valid and ready both high, on either side.
REQ-015 SHALL, in one-hot mode, set out_vec[k] = 1 only for k == in_idx.
REQ-016 SHALL, in thermometer mode, set out_vec[k] = 1 for all k <= in_idx.
REQ-017 SHALL output out_vec = 0 and out_cnt = 0 when in_en = 0, regardless of mode or index.
REQ-018 SHALL compute out_cnt as: 1 (one-hot, en), in_idx+1 (thermometer, en), or 0 (disabled); thermometer with idx = OUT_W-1 gives OUT_W without overflow.
REQ-019 SHALL register the decode, so out_valid rises the cycle after an accepted input (latency 1).
REQ-020 SHALL hold out_vec and out_cnt stable while out_valid = 1 and out_ready = 0.
REQ-021 SHALL never drop or duplicate a request; outputs appear in acceptance order.
REQ-022 SHALL support back-to-back transfers (one per cycle) at full throughput when out_ready is held high.
REQ-023 SHALL NOT combinationally depend on in_valid/in_idx/in_mode/in_en for out_valid, out_vec or out_cnt.
REQ-024 SHALL, in the buffer states EMPTY / ONE / TWO, make these transitions:
  - EMPTY -> ONE on accept.
  - ONE -> EMPTY on drain without accept.
  - ONE stays ONE on simultaneous accept and drain.
  - ONE -> TWO on accept with out_ready = 0.
  - TWO -> ONE on drain.
REQ-025 SHALL ignore input fields when in_valid = 0; no state change.

Reset
REQ-026 SHALL, while rst = 1, force state EMPTY, out_valid = 0, out_vec = 0, out_cnt = 0 and in_ready = 0.
REQ-027 SHALL raise in_ready on the first cycle after rst deasserts.
REQ-028 SHALL discard buffered entries on a reset mid-operation; none are presented after reset.

Configuration
REQ-029 SHALL use macro DECODER_N_PIPE_SKID_EN to select the buffering scheme.
REQ-030 SHALL, when DECODER_N_PIPE_SKID_EN is defined, use a 2-entry skid buffer with in_ready = (state != TWO), a registered signal with no combinational path from out_ready.
REQ-031 SHALL, when DECODER_N_PIPE_SKID_EN is undefined, use a single stage (TWO unreachable) with in_ready = !out_valid || out_ready, a combinational path.

Structure
REQ-032 SHALL take from shared package decoder_pkg:
  - mode enum DEC_ONEHOT = 0, DEC_THERM = 1.
  - buffer-state encoding.
  - IN_W legal-range constants.
REQ-033 SHALL place the two-entry storage and handshake in sub-module dec_skid_buf, parametrised by payload width OUT_W+IN_W+1.
REQ-034 SHALL keep the decode logic combinational in decoder_n_pipe, ahead of dec_skid_buf.

Verification
REQ-035 SHALL cover IN_W=3, one-hot: idx 5, en=1 -> next cycle out_vec=8'b0010_0000, out_cnt=1.
REQ-036 SHALL cover IN_W=3, thermometer: idx 7 -> out_vec=8'hFF, out_cnt=8; idx 0 -> 8'h01, cnt=1.
REQ-037 SHALL cover en=0 with idx 3, either mode -> out_vec=0, out_cnt=0, out_valid=1.
REQ-038 SHALL cover SKID_EN, out_ready=0, three valid inputs idx 1, 2, 3 -> in_ready low after two accepts; release -> 8'h02, 8'h04, 8'h08 in order.
REQ-039 SHALL cover rst=1 asserted while in state TWO -> next cycle out_valid=0, out_vec=0; no stale words after release.
REQ-040 SHALL cover IN_W=6, thermometer, idx 63, 100 back-to-back random transfers with out_ready=1 -> one output per cycle, matching a scoreboard.
